bcd_div_stream: RTL and testbench

Streaming divisibility checker for BCD numbers of arbitrary length. It accepts one BCD digit per cycle, most significant digit first, over a valid/ready handshake and keeps a running remainder modulo a compile-time divisor. When the last digit arrives it presents a result record: divisible flag, remainder and digit count. It sits downstream of the BCD digit sources and generalises the fixed 4-digit, divide-by-3 combinational check to any divisor and any length, with flow control.

---
 rtl/bcd_div_pkg.sv | 24 ++
 rtl/bcd_mod_step.sv | 36 +++
 rtl/bcd_div_stream.sv | 129 ++++++++++++
 tb/tb_bcd_div_stream.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_div_pkg.sv
// bcd_div_pkg
// Shared definitions for the streaming BCD divisibility blocks:
//   - state_t     : ACCUM (taking digits) / RESULT (holding a result record)
//   - DIGIT_W     : width of one BCD digit
//   - rem_width() : bits needed for a remainder modulo a divisor
//   - cnt_width() : bits needed to count up to and including max_digits
package bcd_div_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } state_t;

  function automatic int rem_width(input int divisor);
    return $clog2(divisor);
  endfunction

  function automatic int cnt_width(input int max_digits);
    return $clog2(max_digits + 1);
  endfunction

endpackage

// File: rtl/bcd_mod_step.sv
// bcd_mod_step
// One Horner step of a decimal remainder: next_rem = (10*rem + digit) mod DIVISOR.
// Purely combinational. The reduction is a fixed chain of compare/subtract
// stages against DIVISOR*2^k, so no generic divider is inferred.
// Ports:
//   rem      in  REM_W    current remainder (< DIVISOR)
//   digit    in  DIGIT_W  incoming digit, taken as its binary value (0..15)
//   next_rem out REM_W    updated remainder
module bcd_mod_step
  import bcd_div_pkg::*;
#(
  parameter int DIVISOR = 3,
  localparam int REM_W = rem_width(DIVISOR)
) (
  input  logic [REM_W-1:0]   rem,
  input  logic [DIGIT_W-1:0] digit,
  output logic [REM_W-1:0]   next_rem
);

  // 10*14 + 15 = 155 at most, so 8 bits hold the un-reduced value.
  logic [7:0]  sum;
  logic [11:0] stage [0:8];

  assign sum      = 8'(rem) * 8'd10 + 8'(digit);
  assign stage[0] = {4'b0000, sum};

  // Restoring reduction: subtracting DIVISOR<<7 down to DIVISOR<<0 leaves
  // the value below DIVISOR whenever the input is below DIVISOR<<8.
  for (genvar gi = 0; gi < 8; gi++) begin : g_sub
    localparam logic [11:0] SUB = 12'(DIVISOR) << (7 - gi);
    assign stage[gi+1] = (stage[gi] >= SUB) ? (stage[gi] - SUB) : stage[gi];
  end

  assign next_rem = REM_W'(stage[8]);

endmodule

// File: rtl/bcd_div_stream.sv
// bcd_div_stream
// Streaming divisibility checker: one BCD digit per cycle, MSD first, keeps a
// running remainder modulo DIVISOR and emits a result record per number.
// A number ends on digit_last or after MAX_DIGITS digits (res_trunc=1).
// Optional macro BCD_DIV_CHECK_EN: flags digits above 9 via res_error.
// Ports:
//   clk, rst_n (async, active-low)
//   digit_valid/digit_ready/digit/digit_last : digit input handshake
//   res_valid/res_ready                      : result handshake
//   res_divisible, res_remainder, res_ndigits, res_trunc, res_error : record
module bcd_div_stream
  import bcd_div_pkg::*;
#(
  parameter int DIVISOR    = 3,
  parameter int MAX_DIGITS = 8,
  localparam int REM_W = rem_width(DIVISOR),
  localparam int CNT_W = cnt_width(MAX_DIGITS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               digit_valid,
  output logic               digit_ready,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               digit_last,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_divisible,
  output logic [REM_W-1:0]   res_remainder,
  output logic [CNT_W-1:0]   res_ndigits,
  output logic               res_trunc,
  output logic               res_error
);

  state_t state_reg, state_next;

  logic [REM_W-1:0] rem_reg, rem_step;
  logic [CNT_W-1:0] cnt_reg, cnt_inc;
  logic             err_reg, err_next;
  logic             digit_accept, number_done;

  logic             res_divisible_reg, res_trunc_reg, res_error_reg;
  logic [REM_W-1:0] res_remainder_reg;
  logic [CNT_W-1:0] res_ndigits_reg;

  bcd_mod_step #(.DIVISOR(DIVISOR)) u_step (
    .rem      (rem_step_src()),
    .digit    (digit),
    .next_rem (rem_step)
  );

  function automatic logic [REM_W-1:0] rem_step_src();
    return rem_reg;
  endfunction

  assign cnt_inc      = cnt_reg + 1'b1;
  assign number_done  = digit_last || (cnt_inc == CNT_W'(MAX_DIGITS));
  assign digit_accept = digit_valid && (state_reg == ACCUM);

`ifdef BCD_DIV_CHECK_EN
  assign err_next = err_reg || (digit > 4'd9);
`else
  assign err_next = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ACCUM;
    else        state_reg <= state_next;
  end

  // Handshake outputs decode the registered state only; res_ready never
  // reaches digit_ready combinationally.
  always_comb begin
    state_next  = state_reg;
    digit_ready = 1'b0;
    res_valid   = 1'b0;
    case (state_reg)
      ACCUM: begin
        digit_ready = 1'b1;
        if (digit_valid && number_done) state_next = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg           <= '0;
      cnt_reg           <= '0;
      err_reg           <= 1'b0;
      res_divisible_reg <= 1'b0;
      res_remainder_reg <= '0;
      res_ndigits_reg   <= '0;
      res_trunc_reg     <= 1'b0;
      res_error_reg     <= 1'b0;
    end else if (digit_accept) begin
      if (number_done) begin
        // Capture the record and start the next number from scratch.
        res_remainder_reg <= rem_step;
        res_ndigits_reg   <= cnt_inc;
        res_trunc_reg     <= !digit_last;
        res_error_reg     <= err_next;
        res_divisible_reg <= (rem_step == '0) && !err_next;
        rem_reg           <= '0;
        cnt_reg           <= '0;
        err_reg           <= 1'b0;
      end else begin
        rem_reg <= rem_step;
        cnt_reg <= cnt_inc;
        err_reg <= err_next;
      end
    end
  end

  assign res_divisible = res_divisible_reg;
  assign res_remainder = res_remainder_reg;
  assign res_ndigits   = res_ndigits_reg;
  assign res_trunc     = res_trunc_reg;
`ifdef BCD_DIV_CHECK_EN
  assign res_error     = res_error_reg;
`else
  // No checking in this build: the captured flag is always 0.
  assign res_error     = 1'b0 & res_error_reg;
`endif

endmodule

// File: tb/tb_bcd_div_stream.sv
// tb_bcd_div_stream
// Random and directed digit streams; a reference model builds each number's
// decimal value and pushes the expected record into a queue, a monitor pops
// and compares on every result handshake.
module tb_bcd_div_stream;
  import bcd_div_pkg::*;

  localparam int DIVISOR    = 7;
  localparam int MAX_DIGITS = 5;
  localparam int REM_W = rem_width(DIVISOR);
  localparam int CNT_W = cnt_width(MAX_DIGITS);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               digit_valid = 1'b0;
  logic               digit_ready;
  logic [DIGIT_W-1:0] digit = '0;
  logic               digit_last = 1'b0;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic               res_divisible;
  logic [REM_W-1:0]   res_remainder;
  logic [CNT_W-1:0]   res_ndigits;
  logic               res_trunc;
  logic               res_error;

  bcd_div_stream #(.DIVISOR(DIVISOR), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .digit_valid   (digit_valid),
    .digit_ready   (digit_ready),
    .digit         (digit),
    .digit_last    (digit_last),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_divisible (res_divisible),
    .res_remainder (res_remainder),
    .res_ndigits   (res_ndigits),
    .res_trunc     (res_trunc),
    .res_error     (res_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rem;
    int nd;
    int trunc;
    int err;
    int div;
  } exp_t;

  exp_t exp_q[$];
  int   cur_d[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   rr_mode = 0;   // 0: ready high, 1: random, 2: held low
  int   n_results = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: the number is the decimal value of its digit string; each
  // digit contributes its binary value at its decimal position.
  function automatic void model_close(input bit last);
    exp_t   e;
    longint v = 0;
    int     bad = 0;
    foreach (cur_d[i]) begin
      v = v * 10 + cur_d[i];
      if (cur_d[i] > 9) bad = 1;
    end
`ifdef BCD_DIV_CHECK_EN
    e.err = bad;
`else
    e.err = 0;
`endif
    e.rem   = int'(v % DIVISOR);
    e.nd    = cur_d.size();
    e.trunc = last ? 0 : 1;
    e.div   = (e.rem == 0 && e.err == 0) ? 1 : 0;
    exp_q.push_back(e);
    cur_d.delete();
  endfunction

  // Leaves digit_valid high so consecutive calls stream back to back.
  task automatic send_digit(input int d, input bit last);
    int t = 0;
    cur_d.push_back(d);
    if (last || cur_d.size() == MAX_DIGITS) model_close(last);
    digit_valid = 1'b1;
    digit       = DIGIT_W'(d);
    digit_last  = last;
    while (!digit_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      miscompares++;
      $display("FAIL accept_timeout: digit %0d not accepted, expected accept within 200 cycles", d);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    digit_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t = 0;
    digit_valid = 1'b0;
    while (exp_q.size() > 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  // res_ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    int mcount = 0;
    bit pend = 0;
    bit hold = 0;
    int s_rem = 0, s_nd = 0, s_tr = 0, s_er = 0, s_dv = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mcount = 0;
        pend   = 0;
        hold   = 0;
      end else begin
        check("ready_vs_valid", int'(digit_ready), int'(!res_valid));
        if (pend) check("latency_res_valid", int'(res_valid), 1);
        pend = 0;
        if (hold) begin
          check("frozen_remainder", int'(res_remainder), s_rem);
          check("frozen_ndigits", int'(res_ndigits), s_nd);
          check("frozen_trunc", int'(res_trunc), s_tr);
          check("frozen_error", int'(res_error), s_er);
          check("frozen_divisible", int'(res_divisible), s_dv);
        end
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_result: got a result record, expected none");
          end else begin
            e = exp_q.pop_front();
            n_results++;
            $display("result %0d: rem=%0d nd=%0d trunc=%0d err=%0d div=%0d", n_results,
                     res_remainder, res_ndigits, res_trunc, res_error, res_divisible);
            check("res_remainder", int'(res_remainder), e.rem);
            check("res_ndigits", int'(res_ndigits), e.nd);
            check("res_trunc", int'(res_trunc), e.trunc);
            check("res_error", int'(res_error), e.err);
            check("res_divisible", int'(res_divisible), e.div);
          end
        end
        hold  = res_valid && !res_ready;
        s_rem = int'(res_remainder);
        s_nd  = int'(res_ndigits);
        s_tr  = int'(res_trunc);
        s_er  = int'(res_error);
        s_dv  = int'(res_divisible);
        if (digit_valid && digit_ready) begin
          mcount++;
          if (digit_last || mcount == MAX_DIGITS) begin
            pend   = 1;
            mcount = 0;
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digit_ready"}, int'(digit_ready), 1);
    check({tag, "_res_valid"}, int'(res_valid), 0);
    check({tag, "_res_divisible"}, int'(res_divisible), 0);
    check({tag, "_res_remainder"}, int'(res_remainder), 0);
    check({tag, "_res_ndigits"}, int'(res_ndigits), 0);
    check({tag, "_res_trunc"}, int'(res_trunc), 0);
    check({tag, "_res_error"}, int'(res_error), 0);
  endtask

  initial begin
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 98 and 99 modulo 7
    send_digit(9, 0); send_digit(8, 1);
    send_digit(9, 0); send_digit(9, 1);
    // 1,2,3,6
    send_digit(1, 0); send_digit(2, 0); send_digit(3, 0); send_digit(6, 1);
    drain();

    // Truncation: five 1s end by count, then a lone 2
    send_digit(1, 0); send_digit(1, 0); send_digit(1, 0); send_digit(1, 0);
    send_digit(1, 0); send_digit(2, 1);
    drain();

    // Non-BCD digit
    send_digit(1, 0); send_digit(11, 0); send_digit(1, 1);
    drain();

    // Backpressure: result held while the next digit waits
    rr_mode = 2;
    send_digit(1, 0); send_digit(2, 1);
    fork
      begin
        repeat (6) @(posedge clk);
        rr_mode = 0;
      end
    join_none
    send_digit(4, 1);
    drain();

    // Reset in the middle of a number
    send_digit(5, 0); send_digit(5, 0);
    digit_valid = 1'b0;
    rst_n = 1'b0;
    cur_d.delete();
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_digit(7, 1);
    drain();

    // Random streams with random result backpressure
    rr_mode = 1;
    repeat (250) begin
      int len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        int d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        send_digit(d, i == len - 1);
        if ($urandom_range(0, 5) == 0) idle_cycle();
      end
    end
    drain();
    rr_mode = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
